// File: rtl/l1_mau_arb.sv
// rtl/l1_mau_arb.sv - round-robin arbiter sharing one MAU port between L1I (port 0) and L1D (port 1)
module l1_mau_arb #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BE_W      = 4,
    parameter int LINE_W    = 256,
    parameter int TO_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,

    // port 0: L1I
    input  logic              p0_req_val,
    input  logic              p0_req_nc,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    input  logic [BE_W-1:0]   p0_req_be,
    output logic              p0_req_ack,
    output logic              p0_ack_nc,
    output logic [LINE_W-1:0] p0_ack_data,

    // port 1: L1D
    input  logic              p1_req_val,
    input  logic              p1_req_nc,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    input  logic [BE_W-1:0]   p1_req_be,
    output logic              p1_req_ack,
    output logic              p1_ack_nc,
    output logic [LINE_W-1:0] p1_ack_data,

    // shared MAU interface
    output logic              mau_req_val,
    output logic              mau_req_nc,
    output logic              mau_req_we,
    output logic [ADDR_W-1:0] mau_req_addr,
    output logic [DATA_W-1:0] mau_req_wdata,
    output logic [BE_W-1:0]   mau_req_be,
    input  logic              mau_req_ack,
    input  logic              mau_ack_nc,
    input  logic [LINE_W-1:0] mau_ack_data,

    output logic              grant_o,
    output logic              err_timeout
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Timer wide enough to hold TO_CYCLES itself; a disabled watchdog keeps a 1-bit stub.
    localparam int                TMR_W  = (TO_CYCLES < 1) ? 1 : $clog2(TO_CYCLES + 1);
    localparam logic [TMR_W-1:0]  TO_VAL = TMR_W'(TO_CYCLES);
    localparam bit                WD_EN  = (TO_CYCLES != 0);

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               err_q, err_d;

    logic               busy;
    logic [TMR_W-1:0]   timer_inc;
    logic               ack_ok;

    assign busy = (state_q == ST_BUSY);

    // Next-state: pick a winner in IDLE, hold the grant in BUSY until the MAU acks, run the watchdog.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        timer_d   = '0;
        err_d     = err_q;
        timer_inc = (timer_q == TO_VAL) ? timer_q : timer_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                // a stray MAU ack here is simply not looked at
                if (p0_req_val && p1_req_val) begin
                    grant_d = rr_ptr_q;
                    state_d = ST_BUSY;
                end else if (p0_req_val) begin
                    grant_d = 1'b0;
                    state_d = ST_BUSY;
                end else if (p1_req_val) begin
                    grant_d = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mau_req_ack) begin
                    // loser of this round gets priority next time
                    rr_ptr_d = ~grant_q;
                    state_d  = ST_IDLE;
                end else begin
                    timer_d = timer_inc;
                    if (WD_EN && (timer_inc == TO_VAL)) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and watchdog registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            timer_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
        end
    end

    // An ack counts only while BUSY and outside reset; it is steered to the granted port only.
    assign ack_ok = busy && mau_req_ack && !rst;

    // Ack return path: pass-through to the winner, zeros to the other port.
    always_comb begin
        p0_req_ack  = ack_ok && !grant_q;
        p1_req_ack  = ack_ok &&  grant_q;
        p0_ack_nc   = 1'b0;
        p1_ack_nc   = 1'b0;
        p0_ack_data = '0;
        p1_ack_data = '0;
        if (p0_req_ack) begin
            p0_ack_nc   = mau_ack_nc;
            p0_ack_data = mau_ack_data;
        end
        if (p1_req_ack) begin
            p1_ack_nc   = mau_ack_nc;
            p1_ack_data = mau_ack_data;
        end
    end

    // Request path: live mux from the granted port while BUSY, all zero otherwise.
    always_comb begin
        mau_req_val   = busy;
        mau_req_nc    = 1'b0;
        mau_req_we    = 1'b0;
        mau_req_addr  = '0;
        mau_req_wdata = '0;
        mau_req_be    = '0;
        if (busy) begin
            if (grant_q) begin
                mau_req_nc    = p1_req_nc;
                mau_req_we    = p1_req_we;
                mau_req_addr  = p1_req_addr;
                mau_req_wdata = p1_req_wdata;
                mau_req_be    = p1_req_be;
            end else begin
                mau_req_nc    = p0_req_nc;
                mau_req_we    = p0_req_we;
                mau_req_addr  = p0_req_addr;
                mau_req_wdata = p0_req_wdata;
                mau_req_be    = p0_req_be;
            end
        end
    end

    assign grant_o     = grant_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_l1_mau_arb.sv
// tb/tb_l1_mau_arb.sv - table-driven bench for l1_mau_arb
module tb_l1_mau_arb;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int LINE_W = 256;
    localparam int TO_CYC = 16;

    localparam logic [DATA_W-1:0] P0_WD = 32'h0000_0A0A;
    localparam logic [DATA_W-1:0] P1_WD = 32'h0000_0B0B;
    localparam logic [BE_W-1:0]   P0_BE = 4'h3;
    localparam logic [BE_W-1:0]   P1_BE = 4'hC;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_req_val, p0_req_nc, p0_req_we;
    logic [ADDR_W-1:0] p0_req_addr;
    logic [DATA_W-1:0] p0_req_wdata;
    logic [BE_W-1:0]   p0_req_be;
    logic              p0_req_ack, p0_ack_nc;
    logic [LINE_W-1:0] p0_ack_data;
    logic              p1_req_val, p1_req_nc, p1_req_we;
    logic [ADDR_W-1:0] p1_req_addr;
    logic [DATA_W-1:0] p1_req_wdata;
    logic [BE_W-1:0]   p1_req_be;
    logic              p1_req_ack, p1_ack_nc;
    logic [LINE_W-1:0] p1_ack_data;
    logic              mau_req_val, mau_req_nc, mau_req_we;
    logic [ADDR_W-1:0] mau_req_addr;
    logic [DATA_W-1:0] mau_req_wdata;
    logic [BE_W-1:0]   mau_req_be;
    logic              mau_req_ack, mau_ack_nc;
    logic [LINE_W-1:0] mau_ack_data;
    logic              grant_o, err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    l1_mau_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .LINE_W(LINE_W), .TO_CYCLES(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_req_val(p0_req_val), .p0_req_nc(p0_req_nc), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_be(p0_req_be),
        .p0_req_ack(p0_req_ack), .p0_ack_nc(p0_ack_nc), .p0_ack_data(p0_ack_data),
        .p1_req_val(p1_req_val), .p1_req_nc(p1_req_nc), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_be(p1_req_be),
        .p1_req_ack(p1_req_ack), .p1_ack_nc(p1_ack_nc), .p1_ack_data(p1_ack_data),
        .mau_req_val(mau_req_val), .mau_req_nc(mau_req_nc), .mau_req_we(mau_req_we),
        .mau_req_addr(mau_req_addr), .mau_req_wdata(mau_req_wdata), .mau_req_be(mau_req_be),
        .mau_req_ack(mau_req_ack), .mau_ack_nc(mau_ack_nc), .mau_ack_data(mau_ack_data),
        .grant_o(grant_o), .err_timeout(err_timeout)
    );

    typedef struct {
        logic        rst, v0, v1;
        logic [31:0] a0, a1;
        logic        nc1, ack, anc;
        logic [31:0] aw;
        logic        e_mval;
        logic [31:0] e_addr;
        logic        e_mnc, e_gnt, e_k0, e_k1;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r, v0, v1, input logic [31:0] a0, a1,
                                input logic nc1, ack, anc, input logic [31:0] aw,
                                input logic mval, input logic [31:0] addr,
                                input logic mnc, gnt, k0, k1);
        vec_t v;
        v.rst = r; v.v0 = v0; v.v1 = v1; v.a0 = a0; v.a1 = a1;
        v.nc1 = nc1; v.ack = ack; v.anc = anc; v.aw = aw;
        v.e_mval = mval; v.e_addr = addr; v.e_mnc = mnc; v.e_gnt = gnt;
        v.e_k0 = k0; v.e_k1 = k1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        p0_req_val = 0; p0_req_nc = 0; p0_req_we = 0; p0_req_addr = '0;
        p1_req_val = 0; p1_req_nc = 0; p1_req_we = 1; p1_req_addr = '0;
        p0_req_wdata = P0_WD; p0_req_be = P0_BE;
        p1_req_wdata = P1_WD; p1_req_be = P1_BE;
        mau_req_ack = 0; mau_ack_nc = 0; mau_ack_data = '0;
    endtask

    initial begin
        logic [LINE_W-1:0] line;
        logic              exp_we;
        logic [DATA_W-1:0] exp_wd;
        logic [BE_W-1:0]   exp_be;
        int                k;
        bit                found;

        rst = 1;
        idle_inputs();
        repeat (2) @(posedge clk);

        //     rst v0 v1 a0      a1      nc1 ack anc aw            | mval addr    mnc gnt k0 k1
        vt.push_back(mk(0,0,0,0,0,              0,0,0,0,            0,0,      0,0,0,0));
        vt.push_back(mk(0,1,0,32'h100,0,        0,0,0,0,            0,0,      0,0,0,0));
        vt.push_back(mk(0,1,0,32'h100,0,        0,0,0,0,            1,32'h100,0,0,0,0));
        vt.push_back(mk(0,1,0,32'h100,0,        0,0,0,0,            1,32'h100,0,0,0,0));
        vt.push_back(mk(0,1,0,32'h100,0,        0,1,0,32'hABABABAB, 1,32'h100,0,0,1,0));
        vt.push_back(mk(0,0,0,0,0,              0,0,0,0,            0,0,      0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,              0,1,0,32'h55555555, 0,0,      0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,              0,0,0,0,            0,0,      0,0,0,0));
        vt.push_back(mk(0,1,1,32'h200,32'h300,  0,0,0,0,            0,0,      0,0,0,0));
        vt.push_back(mk(0,1,1,32'h200,32'h300,  0,1,0,32'h11111111, 1,32'h300,0,1,0,1));
        vt.push_back(mk(0,1,0,32'h200,0,        0,0,0,0,            0,0,      0,1,0,0));
        vt.push_back(mk(0,1,0,32'h200,0,        0,1,0,32'h22222222, 1,32'h200,0,0,1,0));
        vt.push_back(mk(0,0,0,0,0,              0,0,0,0,            0,0,      0,0,0,0));
        vt.push_back(mk(0,0,1,0,32'h400,        1,0,0,0,            0,0,      0,0,0,0));
        vt.push_back(mk(0,0,1,0,32'h400,        1,1,1,32'h00001234, 1,32'h400,1,1,0,1));
        vt.push_back(mk(0,0,0,0,0,              0,0,0,0,            0,0,      0,1,0,0));
        vt.push_back(mk(0,1,0,32'h500,0,        0,0,0,0,            0,0,      0,1,0,0));
        vt.push_back(mk(0,0,0,32'h500,0,        0,0,0,0,            1,32'h500,0,0,0,0));
        vt.push_back(mk(0,0,0,32'h500,0,        0,1,0,32'h33333333, 1,32'h500,0,0,1,0));
        vt.push_back(mk(0,0,0,0,0,              0,0,0,0,            0,0,      0,0,0,0));
        vt.push_back(mk(0,0,1,0,32'h600,        0,0,0,0,            0,0,      0,0,0,0));
        vt.push_back(mk(0,0,1,0,32'h600,        0,0,0,0,            1,32'h600,0,1,0,0));
        vt.push_back(mk(0,0,1,0,32'h600,        0,0,0,0,            1,32'h600,0,1,0,0));
        vt.push_back(mk(1,0,1,0,32'h600,        0,1,0,32'h44444444, 1,32'h600,0,1,0,0));
        vt.push_back(mk(0,0,1,0,32'h600,        0,0,0,0,            0,0,      0,0,0,0));
        vt.push_back(mk(0,0,1,0,32'h600,        0,1,0,32'h66666666, 1,32'h600,0,1,0,1));
        vt.push_back(mk(0,0,0,0,0,              0,0,0,0,            0,0,      0,1,0,0));

        foreach (vt[i]) begin
            @(negedge clk);
            rst          = vt[i].rst;
            p0_req_val   = vt[i].v0;  p0_req_addr = vt[i].a0;
            p1_req_val   = vt[i].v1;  p1_req_addr = vt[i].a1;  p1_req_nc = vt[i].nc1;
            mau_req_ack  = vt[i].ack; mau_ack_nc  = vt[i].anc;
            line         = {8{vt[i].aw}};
            mau_ack_data = line;
            #1;
            exp_we = vt[i].e_mval && vt[i].e_gnt;
            exp_wd = !vt[i].e_mval ? '0 : (vt[i].e_gnt ? P1_WD : P0_WD);
            exp_be = !vt[i].e_mval ? '0 : (vt[i].e_gnt ? P1_BE : P0_BE);
            chk($sformatf("v%0d.mau_req_val", i),   mau_req_val,   vt[i].e_mval);
            chk($sformatf("v%0d.mau_req_addr", i),  mau_req_addr,  vt[i].e_addr);
            chk($sformatf("v%0d.mau_req_nc", i),    mau_req_nc,    vt[i].e_mnc);
            chk($sformatf("v%0d.mau_req_we", i),    mau_req_we,    exp_we);
            chk($sformatf("v%0d.mau_req_wdata", i), mau_req_wdata, exp_wd);
            chk($sformatf("v%0d.mau_req_be", i),    mau_req_be,    exp_be);
            chk($sformatf("v%0d.grant_o", i),       grant_o,       vt[i].e_gnt);
            chk($sformatf("v%0d.p0_req_ack", i),    p0_req_ack,    vt[i].e_k0);
            chk($sformatf("v%0d.p1_req_ack", i),    p1_req_ack,    vt[i].e_k1);
            chk($sformatf("v%0d.p0_ack_nc", i),     p0_ack_nc,     vt[i].e_k0 & vt[i].anc);
            chk($sformatf("v%0d.p1_ack_nc", i),     p1_ack_nc,     vt[i].e_k1 & vt[i].anc);
            chk($sformatf("v%0d.p0_ack_data", i),   p0_ack_data,   vt[i].e_k0 ? line : '0);
            chk($sformatf("v%0d.p1_ack_data", i),   p1_ack_data,   vt[i].e_k1 ? line : '0);
            chk($sformatf("v%0d.err_timeout", i),   err_timeout,   1'b0);
        end

        // Round-robin alternation over 8 rounds with both ports permanently requesting.
        @(negedge clk);
        idle_inputs();
        rst = 1;
        p0_req_val = 1; p0_req_addr = 32'h700;
        p1_req_val = 1; p1_req_addr = 32'h800;
        @(negedge clk);
        rst = 0;
        for (int r = 0; r < 8; r++) begin
            found = 0;
            for (int w = 0; w < 6 && !found; w++) begin
                @(negedge clk);
                #1;
                if (mau_req_val) found = 1;
            end
            chk($sformatf("rr%0d.req_seen", r), found, 1'b1);
            chk($sformatf("rr%0d.grant", r), grant_o, r[0]);
            chk($sformatf("rr%0d.addr", r), mau_req_addr, r[0] ? 32'h800 : 32'h700);
            mau_req_ack  = 1;
            mau_ack_data = {8{32'hC0DE0000 + 32'(r)}};
            #1;
            chk($sformatf("rr%0d.p0_ack", r), p0_req_ack, !r[0]);
            chk($sformatf("rr%0d.p1_ack", r), p1_req_ack,  r[0]);
            @(negedge clk);
            mau_req_ack  = 0;
            mau_ack_data = '0;
        end

        // Watchdog: no ack for more than TO_CYC busy cycles, sticky until reset.
        @(negedge clk);
        idle_inputs();
        rst = 1;
        @(negedge clk);
        rst = 0;
        p0_req_val = 1; p0_req_addr = 32'h900;
        k = 0;
        found = 0;
        for (int w = 0; w < 40 && !found; w++) begin
            @(negedge clk);
            #1;
            if (mau_req_val) begin
                k++;
                if (k == TO_CYC)     chk("wd.err_before", err_timeout, 1'b0);
                if (k == TO_CYC + 1) begin
                    chk("wd.err_after", err_timeout, 1'b1);
                    found = 1;
                end
            end
        end
        chk("wd.reached", found, 1'b1);
        @(negedge clk);
        mau_req_ack = 1;
        #1;
        chk("wd.late_ack", p0_req_ack, 1'b1);
        @(negedge clk);
        mau_req_ack = 0;
        p0_req_val  = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("wd.sticky", err_timeout, 1'b1);
        chk("wd.idle", mau_req_val, 1'b0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        chk("wd.cleared", err_timeout, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
